hc595_monitor: RTL and testbench
================================

HC595_MONITOR -- requirements
Module: hc595_monitor

Interface
REQ-001 FRAME_BITS, 16, number of bits shifted per strobe frame.
REQ-002 TIMEOUT, 4096, sys_clk cycles without a segled_clk edge before a partial frame is discarded.
REQ-003 sys_clk  input  1  system clock, 50 MHz; all logic in this single domain.
REQ-004 sys_rst  input  1  reset, asynchronous assert, active-high.
REQ-005 segled_clk  input  1  595 shift clock; asynchronous to sys_clk.
REQ-006 segled_dat  input  1  595 serial data, MSB first.
REQ-007 segled_str  input  1  595 storage strobe (RCLK).
REQ-008 frame_data  output  FRAME_BITS  last latched frame.
REQ-009 frame_valid  output  1  one-cycle pulse per latched frame.
REQ-010 frame_err  output  1  with frame_valid: bit count at strobe differed from FRAME_BITS.
REQ-011 sel_err  output  1  with frame_valid: digit-select field not one-hot.
REQ-012 seg_mirror  output  32  four 8-bit segment bytes, digit0 in [7:0] through digit3 in [31:24].
REQ-013 frame_cnt  output  16  count of latched frames; wraps at 0xFFFF to 0.

Function
REQ-014 Each of segled_clk, segled_dat and segled_str SHALL pass through a 2-flop synchronizer, followed by one delay register for edge detection.
REQ-015 A synchronized segled_clk rising edge SHALL shift segled_dat into the LSB of the shift register, shifting earlier bits toward the MSB, and increment bit_cnt, which saturates at FRAME_BITS+1.
REQ-016 A synchronized segled_str rising edge SHALL do the following in one cycle:
- copy the shift register to frame_data;
- pulse frame_valid;
- set frame_err = (bit_cnt != FRAME_BITS);
- clear bit_cnt;
- increment frame_cnt.
REQ-017 frame_valid SHALL assert exactly 3 sys_clk cycles after the segled_str pin rises, given setup to sys_clk.
REQ-018 Simultaneous clk and str edges in the same cycle SHALL follow 595 semantics:
- frame_data latches the pre-shift contents;
- the shift still occurs;
- bit_cnt restarts at 1.
REQ-019 Frame field layout: frame_data[15:8] is the segment byte; frame_data[3:0] is digit select, active-high one-hot; frame_data[7:4] must be zero.
REQ-020 On a strobe with frame_err=0 and a valid select, the segment byte SHALL be written to the selected seg_mirror byte in the same cycle frame_valid asserts.
REQ-021 If the select field is zero, not one-hot, or frame_data[7:4] != 0, sel_err SHALL assert and seg_mirror SHALL be unchanged.
REQ-022 If frame_err is 1, seg_mirror SHALL be unchanged.
REQ-023 Timeout counter:
- cleared by any clk or str edge;
- counts while bit_cnt != 0;
- on reaching TIMEOUT, bit_cnt clears and the shift register is retained.
A subsequent strobe with no new bits therefore reports frame_err=1.
REQ-024 Receive FSM states: IDLE (bit_cnt=0) and SHIFTING (bit_cnt>0).
- IDLE->SHIFTING on a clk edge.
- SHIFTING->IDLE on a strobe or a timeout.
- A strobe in IDLE latches with frame_err=1 unless FRAME_BITS=0.
REQ-025 All outputs SHALL be registered.

Reset
REQ-026 While sys_rst=1, the following SHALL be 0: synchronizers, shift register, bit_cnt, timeout counter, frame_data, frame_valid, frame_err, sel_err, seg_mirror, frame_cnt.
REQ-027 Reset mid-frame SHALL discard partial bits; the first strobe after reset with fewer than FRAME_BITS bits SHALL report frame_err=1.
REQ-028 Edge detectors SHALL NOT report an edge in the first cycle after reset release, even if a pin is already high.

Structure
REQ-029 Shared package hc595_pkg SHALL hold FRAME_BITS default, the segment/select field positions, and the digit count (4).
REQ-030 One sub-module, sync_edge (2-flop synchronizer plus rising-edge pulse), SHALL be instantiated three times.

Verification
REQ-031 Shift 16 bits 0x3F01 then strobe -> frame_data=0x3F01, frame_err=0, sel_err=0, seg_mirror[7:0]=0x3F, frame_cnt=1.
REQ-032 Shift 15 bits then strobe -> frame_err=1, seg_mirror unchanged.
REQ-033 Frame 0x0603 (two selects set) -> sel_err=1, seg_mirror unchanged, frame_valid still pulses.
REQ-034 Shift 8 bits, idle 4096 cycles, shift 16 bits 0x5B04, strobe -> frame_err=0, seg_mirror[23:16]=0x5B.
REQ-035 Clk and str rise together after 16 bits 0x6D08 -> frame_data=0x6D08, bit_cnt=1 afterwards.
REQ-036 Assert sys_rst after 10 bits, release, strobe -> all outputs 0 during reset, frame_err=1 on the strobe, frame_valid 3 cycles after the str pin edge.

Source files
------------

// File: rtl/hc595_pkg.sv
// hc595_pkg: shared constants, state type and frame-field helper for the 595 monitor
package hc595_pkg;
    localparam int FRAME_BITS = 16;
    localparam int DIGITS     = 4;
    localparam int SEG_LSB    = 8;
    localparam int SEG_W      = 8;
    localparam int SEL_LSB    = 0;
    localparam int SEL_W      = DIGITS;
    localparam int PAD_LSB    = 4;
    localparam int PAD_W      = 4;
    localparam int CNT_W      = $clog2(FRAME_BITS + 2);

    typedef enum logic {IDLE, SHIFTING} rx_state_t;

    function automatic logic sel_ok(input logic [FRAME_BITS-1:0] f);
        return f[PAD_LSB +: PAD_W] == '0 && $onehot(f[SEL_LSB +: SEL_W]);
    endfunction
endpackage

// File: rtl/hc595_if.sv
// hc595_if: 595 pin bundle plus the monitor's decoded results
interface hc595_if;
    import hc595_pkg::*;
    logic                      segled_clk;
    logic                      segled_dat;
    logic                      segled_str;
    logic [FRAME_BITS-1:0]     frame_data;
    logic                      frame_valid;
    logic                      frame_err;
    logic                      sel_err;
    logic [DIGITS*SEG_W-1:0]   seg_mirror;
    logic [15:0]               frame_cnt;

    modport master (
        output segled_clk, segled_dat, segled_str,
        input  frame_data, frame_valid, frame_err, sel_err, seg_mirror, frame_cnt
    );
    modport slave (
        input  segled_clk, segled_dat, segled_str,
        output frame_data, frame_valid, frame_err, sel_err, seg_mirror, frame_cnt
    );
endinterface

// File: rtl/sync_edge.sv
// sync_edge: 2-flop synchronizer with a delay register for rising-edge detection
module sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic level,
    output logic rise
);
    logic s1, s2, dly;

    // Metastability chain followed by the edge-detect delay stage
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            s1  <= 1'b0;
            s2  <= 1'b0;
            dly <= 1'b0;
        end else begin
            s1  <= d;
            s2  <= s1;
            dly <= s2;
        end

    assign level = s2;
    assign rise  = s2 & ~dly;
endmodule

// File: rtl/hc595_monitor.sv
// hc595_monitor: snoops a 74HC595 serial bus, latches frames and mirrors the segment bytes
module hc595_monitor
    import hc595_pkg::*;
#(
    parameter int TIMEOUT = 4096
) (
    input logic    sys_clk,
    input logic    sys_rst,
    hc595_if.slave bus
);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(FRAME_BITS + 1);
    localparam logic [TW-1:0]    T_LAST   = TW'(TIMEOUT - 1);

    logic clk_rise, str_rise, dat;
    logic clk_lvl_unused, str_lvl_unused, dat_rise_unused;
    rx_state_t state, state_nxt;
    logic [FRAME_BITS-1:0] sr;
    logic [CNT_W-1:0] bit_cnt;
    logic [TW-1:0] tcnt;
    logic counting, timeout;

    sync_edge u_clk (.clk(sys_clk), .rst(sys_rst), .d(bus.segled_clk), .level(clk_lvl_unused), .rise(clk_rise));
    sync_edge u_dat (.clk(sys_clk), .rst(sys_rst), .d(bus.segled_dat), .level(dat), .rise(dat_rise_unused));
    sync_edge u_str (.clk(sys_clk), .rst(sys_rst), .d(bus.segled_str), .level(str_lvl_unused), .rise(str_rise));

    // Receive state register
    always_ff @(posedge sys_clk or posedge sys_rst)
        if (sys_rst) state <= IDLE;
        else state <= state_nxt;

    // A shift edge always leaves us mid-frame (even alongside a strobe); a lone strobe or a stall ends it
    always_comb
        state_nxt = clk_rise ? SHIFTING : (str_rise || timeout) ? IDLE : state;

    // Stall timer runs only mid-frame and only in cycles with no edge
    always_comb begin
        counting = state == SHIFTING && !clk_rise && !str_rise;
        timeout  = counting && tcnt == T_LAST;
    end

    // Shift register, saturating bit counter and stall timer; a stall keeps the shifted bits
    always_ff @(posedge sys_clk or posedge sys_rst)
        if (sys_rst) begin
            sr      <= '0;
            bit_cnt <= '0;
            tcnt    <= '0;
        end else begin
            if (clk_rise) sr <= {sr[FRAME_BITS-2:0], dat};
            bit_cnt <= str_rise ? (clk_rise ? CNT_ONE : '0)
                     : clk_rise ? (bit_cnt == CNT_SAT ? bit_cnt : bit_cnt + CNT_ONE)
                     : timeout ? '0 : bit_cnt;
            tcnt    <= (counting && !timeout) ? tcnt + TW'(1) : '0;
        end

    // Strobe latches the pre-shift register and updates one mirror byte for clean frames
    always_ff @(posedge sys_clk or posedge sys_rst)
        if (sys_rst) begin
            bus.frame_data  <= '0;
            bus.frame_valid <= 1'b0;
            bus.frame_err   <= 1'b0;
            bus.sel_err     <= 1'b0;
            bus.seg_mirror  <= '0;
            bus.frame_cnt   <= '0;
        end else begin
            bus.frame_valid <= str_rise;
            bus.frame_err   <= str_rise && bit_cnt != CNT_FULL;
            bus.sel_err     <= str_rise && !sel_ok(sr);
            if (str_rise) begin
                bus.frame_data <= sr;
                bus.frame_cnt  <= bus.frame_cnt + 16'd1;
            end
            if (str_rise && bit_cnt == CNT_FULL && sel_ok(sr))
                for (int i = 0; i < DIGITS; i++)
                    if (sr[SEL_LSB + i]) bus.seg_mirror[SEG_W*i +: SEG_W] <= sr[SEG_LSB +: SEG_W];
        end
endmodule

// File: tb/tb_hc595_monitor.sv
// tb_hc595_monitor: directed 595 traffic checked against a bit-history model of the monitor
module tb_hc595_monitor;
    localparam int TO = 4096;

    logic clk = 1'b0;
    logic rst = 1'b1;
    hc595_if bus();
    hc595_monitor #(.TIMEOUT(TO)) dut (.sys_clk(clk), .sys_rst(rst), .bus(bus));

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic [15:0] d;
        logic        e;
        logic        s;
        logic [31:0] m;
        logic [15:0] c;
    } exp_t;

    exp_t pend[$];
    bit   hist[$];
    int   nbits = 0, last_edge = 0, cyc = 0, n_cmp = 0, n_bad = 0;
    int   str_cyc = 0, valid_cyc = -1;
    logic [15:0] m_cnt = '0, v_data = '0, v_cnt = '0;
    logic [31:0] m_mirror = '0, v_mirror = '0;
    logic seen_err, seen_sel;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    function automatic logic [15:0] frame_now();
        logic [15:0] v = '0;
        for (int i = 0; i < 16; i++)
            if (i < hist.size()) v[i] = hist[hist.size() - 1 - i];
        return v;
    endfunction

    task automatic note_edge();
        if (nbits > 0 && cyc - last_edge > TO) nbits = 0;
        last_edge = cyc;
    endtask

    task automatic latch(input logic [15:0] f, input bit clash);
        exp_t x;
        logic [3:0] sel;
        sel   = f[3:0];
        x.due = cyc + 3;
        x.d   = f;
        x.e   = nbits != 16;
        x.s   = !(f[7:4] == 4'h0 && sel inside {4'h1, 4'h2, 4'h4, 4'h8});
        if (!x.e && !x.s)
            for (int k = 0; k < 4; k++)
                if (sel == 4'(1 << k)) m_mirror[8*k +: 8] = f[15:8];
        m_cnt++;
        x.m = m_mirror;
        x.c = m_cnt;
        pend.push_back(x);
        nbits = clash ? 1 : 0;
        str_cyc = cyc;
        seen_err = 1'bx;
        seen_sel = 1'bx;
        valid_cyc = -1;
    endtask

    task automatic shift_bit(input bit b);
        bus.segled_dat = b;
        tick(2);
        note_edge();
        hist.push_back(b);
        nbits++;
        bus.segled_clk = 1'b1;
        tick(3);
        bus.segled_clk = 1'b0;
        tick(3);
    endtask

    task automatic send(input logic [15:0] w, input int n);
        for (int i = n - 1; i >= 0; i--) shift_bit(w[i]);
    endtask

    task automatic strobe();
        note_edge();
        latch(frame_now(), 1'b0);
        bus.segled_str = 1'b1;
        tick(3);
        bus.segled_str = 1'b0;
        tick(3);
    endtask

    task automatic clash_strobe(input bit b);
        bus.segled_dat = b;
        tick(2);
        note_edge();
        latch(frame_now(), 1'b1);
        hist.push_back(b);
        bus.segled_clk = 1'b1;
        bus.segled_str = 1'b1;
        tick(3);
        bus.segled_clk = 1'b0;
        bus.segled_str = 1'b0;
        tick(3);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        hist.delete();
        pend.delete();
        nbits = 0;
        m_cnt = '0;
        m_mirror = '0;
        v_data = '0;
        v_cnt = '0;
        v_mirror = '0;
        @(negedge clk);
        chk("rst.data", bus.frame_data, 0);
        chk("rst.valid", bus.frame_valid, 0);
        chk("rst.err", bus.frame_err, 0);
        chk("rst.sel", bus.sel_err, 0);
        chk("rst.mirror", bus.seg_mirror, 0);
        chk("rst.cnt", bus.frame_cnt, 0);
        tick(3);
        rst = 1'b0;
        tick(2);
    endtask

    task automatic pin(input string n, input logic [15:0] d, input logic [31:0] m,
                       input logic [15:0] c, input bit e, input bit s);
        @(negedge clk);
        chk({n, ".data"}, bus.frame_data, d);
        chk({n, ".mirror"}, bus.seg_mirror, m);
        chk({n, ".cnt"}, bus.frame_cnt, c);
        chk({n, ".err"}, seen_err, e);
        chk({n, ".sel"}, seen_sel, s);
        chk({n, ".latency"}, valid_cyc - str_cyc, 3);
    endtask

    // Cycle-by-cycle comparison against the model
    initial forever begin
        @(negedge clk);
        if (pend.size() > 0 && cyc == pend[0].due) begin
            chk("valid_pulse", bus.frame_valid, 1);
            chk("frame_err", bus.frame_err, pend[0].e);
            chk("sel_err", bus.sel_err, pend[0].s);
            v_data = pend[0].d;
            v_mirror = pend[0].m;
            v_cnt = pend[0].c;
            void'(pend.pop_front());
        end else
            chk("valid_idle", bus.frame_valid, 0);
        chk("frame_data", bus.frame_data, v_data);
        chk("seg_mirror", bus.seg_mirror, v_mirror);
        chk("frame_cnt", bus.frame_cnt, v_cnt);
        if (bus.frame_valid) begin
            seen_err = bus.frame_err;
            seen_sel = bus.sel_err;
            valid_cyc = cyc;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bus.segled_clk = 1'b0;
        bus.segled_dat = 1'b0;
        bus.segled_str = 1'b0;
        do_reset();
        send(16'h3F01, 16);
        strobe();
        pin("f1", 16'h3F01, 32'h0000_003F, 16'd1, 1'b0, 1'b0);
        send(16'h0204, 15);
        strobe();
        pin("f2", 16'h8204, 32'h0000_003F, 16'd2, 1'b1, 1'b0);
        send(16'h0603, 16);
        strobe();
        pin("f3", 16'h0603, 32'h0000_003F, 16'd3, 1'b0, 1'b1);
        send(16'h00AA, 8);
        tick(4200);
        send(16'h5B04, 16);
        strobe();
        pin("f4", 16'h5B04, 32'h005B_003F, 16'd4, 1'b0, 1'b0);
        send(16'h6D08, 16);
        clash_strobe(1'b0);
        pin("f5", 16'h6D08, 32'h6D5B_003F, 16'd5, 1'b0, 1'b0);
        send(16'h0102, 15);
        strobe();
        pin("f6", 16'h0102, 32'h6D5B_013F, 16'd6, 1'b0, 1'b0);
        send(16'h3F11, 16);
        strobe();
        pin("f7", 16'h3F11, 32'h6D5B_013F, 16'd7, 1'b0, 1'b1);
        send(16'h03FF, 10);
        do_reset();
        strobe();
        pin("f8", 16'h0000, 32'h0000_0000, 16'd1, 1'b1, 1'b1);
        tick(4);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
